// File: rtl/mips_pkg.sv
// Shared constants for the MIPS single-cycle datapath.
//   WL       - data word length in bits
//   AW       - register address width (depth = 2**AW)
//   REG_*    - architecturally special register indices
//   SP_INIT  - reset value of the stack pointer ($sp)
package mips_pkg;

  localparam int unsigned WL = 32;
  localparam int unsigned AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [31:0] SP_INIT = 32'h0000_03FC;

endpackage

// File: rtl/rf_bypass_mux.sv
// Read-port output select for the register file.
// Ports:
//   read_addr  - register index being read
//   array_data - committed array contents at read_addr
//   write_en   - write port enable
//   write_addr - write port destination index
//   write_data - write port value
//   reset      - synchronous reset currently asserted
//   read_data  - value presented to the datapath
// Address 0 is forced to zero. A matching, live write is forwarded so a reader sees the
// value that will be committed at the coming edge. Reset suppresses forwarding because
// that write is about to be dropped.
module rf_bypass_mux #(
  parameter int unsigned WL = 32,
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] read_addr,
  input  logic [WL-1:0] array_data,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  logic [WL-1:0] write_data,
  input  logic          reset,
  output logic [WL-1:0] read_data
);

  logic read_is_zero;
  logic write_live;
  logic bypass_hit;

  assign read_is_zero = (read_addr == '0);
  assign write_live   = write_en && !reset && (write_addr != '0);
  assign bypass_hit   = write_live && (read_addr == write_addr);

  always_comb begin
    read_data = array_data;
    if (read_is_zero) begin
      read_data = '0;
    end else if (bypass_hit) begin
      read_data = write_data;
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// 32 x WL general-purpose register file with $zero hardwiring, write-through bypass on
// both read ports and an unbypassed debug read port.
// Ports:
//   Clk, Reset                    - clock and synchronous active-high reset
//   RF_Read_Addr1 / RF_Read_Data1 - rs port (ALU_In1)
//   RF_Read_Addr2 / RF_Read_Data2 - rt port (ALU_In2 / store data)
//   RF_Write_En/Addr/Data         - writeback port, committed at the rising edge
//   RF_Debug_Addr / RF_Debug_Data - committed-state inspection port
module mips_register_file #(
  parameter int unsigned WL      = mips_pkg::WL,
  parameter int unsigned AW      = mips_pkg::AW,
  parameter logic [WL-1:0] SP_INIT = WL'(mips_pkg::SP_INIT)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] RF_Read_Addr1,
  input  logic [AW-1:0] RF_Read_Addr2,
  output logic [WL-1:0] RF_Read_Data1,
  output logic [WL-1:0] RF_Read_Data2,
  input  logic          RF_Write_En,
  input  logic [AW-1:0] RF_Write_Addr,
  input  logic [WL-1:0] RF_Write_Data,
  input  logic [AW-1:0] RF_Debug_Addr,
  output logic [WL-1:0] RF_Debug_Data
);

  import mips_pkg::*;

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW-1:0] SpIdx = AW'(REG_SP);

  logic [WL-1:0] regs_q [Depth];

  // Reset wins over a same-cycle write; entry 0 is never written and stays zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[SpIdx] <= SP_INIT;
    end else if (RF_Write_En && (RF_Write_Addr != '0)) begin
      regs_q[RF_Write_Addr] <= RF_Write_Data;
    end
  end

  rf_bypass_mux #(
    .WL (WL),
    .AW (AW)
  ) u_mux_rs (
    .read_addr  (RF_Read_Addr1),
    .array_data (regs_q[RF_Read_Addr1]),
    .write_en   (RF_Write_En),
    .write_addr (RF_Write_Addr),
    .write_data (RF_Write_Data),
    .reset      (Reset),
    .read_data  (RF_Read_Data1)
  );

  rf_bypass_mux #(
    .WL (WL),
    .AW (AW)
  ) u_mux_rt (
    .read_addr  (RF_Read_Addr2),
    .array_data (regs_q[RF_Read_Addr2]),
    .write_en   (RF_Write_En),
    .write_addr (RF_Write_Addr),
    .write_data (RF_Write_Data),
    .reset      (Reset),
    .read_data  (RF_Read_Data2)
  );

  always_comb begin
    RF_Debug_Data = regs_q[RF_Debug_Addr];
    if (RF_Debug_Addr == '0) begin
      RF_Debug_Data = '0;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_mips_register_file;

  localparam logic [31:0] SpInit = 32'h0000_03FC;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, da;
  logic [31:0] rd1, rd2, wd, dd;
  logic        we;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  mips_register_file dut (
    .Clk           (clk),
    .Reset         (reset),
    .RF_Read_Addr1 (ra1),
    .RF_Read_Addr2 (ra2),
    .RF_Read_Data1 (rd1),
    .RF_Read_Data2 (rd2),
    .RF_Write_En   (we),
    .RF_Write_Addr (wa),
    .RF_Write_Data (wd),
    .RF_Debug_Addr (da),
    .RF_Debug_Data (dd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read-port value: committed model, with a live write forwarded.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && !reset && wa != 0 && wa == a) return wd;
    return model[a];
  endfunction

  function automatic logic [31:0] exp_debug(input logic [4:0] a);
    if (a == 0) return 32'h0;
    return model[a];
  endfunction

  // Advance one rising edge, update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[29] = SpInit;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4];
    addrs[0] = 5'd0; addrs[1] = 5'd1; addrs[2] = 5'd29; addrs[3] = 5'd31;
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; da = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = (addrs[i] == 5'd29) ? SpInit : 32'h0;
      ra1 = addrs[i]; ra2 = addrs[i]; da = addrs[i];
      #1;
      checks++;
      if (rd1 !== e || rd2 !== e || dd !== e) begin
        errors++;
        $display("FAIL reset_read addr=%0d got rd1=%h rd2=%h dbg=%h want %h",
                 addrs[i], rd1, rd2, dd, e);
      end
    end
  endtask

  task automatic test_write_bypass();
    we = 1'b1; wa = 5'd8; wd = 32'hDEAD_BEEF; ra1 = 5'd8; ra2 = 5'd0; da = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_rd1 got %h want %h", rd1, 32'hDEAD_BEEF);
    end
    checks++;
    if (dd !== 32'h0) begin
      errors++;
      $display("FAIL debug_not_bypassed got %h want %h", dd, 32'h0);
    end
    tick();
    we = 1'b0; ra2 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF || dd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL committed_8 got rd1=%h rd2=%h dbg=%h want DEADBEEF", rd1, rd2, dd);
    end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0; da = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0 || dd !== 32'h0) begin
      errors++;
      $display("FAIL zero_during got rd1=%h rd2=%h dbg=%h want 0", rd1, rd2, dd);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0 || dd !== 32'h0) begin
      errors++;
      $display("FAIL zero_after got rd1=%h rd2=%h dbg=%h want 0", rd1, rd2, dd);
    end
  endtask

  task automatic test_dual_bypass_reset_wins();
    we = 1'b1; wa = 5'd31; wd = 32'h1234_5678; ra1 = 5'd31; ra2 = 5'd31; da = 5'd31;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678 || rd2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dual_bypass got rd1=%h rd2=%h want 12345678", rd1, rd2);
    end
    tick();
    reset = 1'b1; wd = 32'hA5A5_A5A5;
    #1;
    // Bypass suppressed under reset: pre-reset contents visible.
    checks++;
    if (rd1 !== 32'h1234_5678 || rd2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL no_bypass_in_reset got rd1=%h rd2=%h want 12345678", rd1, rd2);
    end
    tick();
    reset = 1'b0; we = 1'b0; ra2 = 5'd29;
    #1;
    checks++;
    if (rd1 !== 32'h0 || dd !== 32'h0) begin
      errors++;
      $display("FAIL reset_wins got rd1=%h dbg=%h want 0", rd1, dd);
    end
    checks++;
    if (rd2 !== SpInit) begin
      errors++;
      $display("FAIL sp_after_reset got %h want %h", rd2, SpInit);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wa = 5'd5; wd = 32'd7; ra1 = 5'd5; ra2 = 5'd6; da = 5'd6;
    #1;
    checks++;
    if (rd1 !== 32'd7 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL b2b_first got rd1=%h rd2=%h want 7/0", rd1, rd2);
    end
    tick();
    wd = 32'd9;
    #1;
    checks++;
    if (rd1 !== 32'd9 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second got rd1=%h rd2=%h want 9/0", rd1, rd2);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'd9 || rd2 !== 32'h0 || dd !== 32'h0) begin
      errors++;
      $display("FAIL b2b_after got rd1=%h rd2=%h dbg=%h want 9/0/0", rd1, rd2, dd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      we    = $urandom_range(0, 1) == 1;
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      da    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rd1 !== exp_read(ra1) || rd2 !== exp_read(ra2) || dd !== exp_debug(da)) begin
        errors++;
        $display("FAIL random[%0d] a1=%0d a2=%0d ad=%0d got %h %h %h want %h %h %h",
                 n, ra1, ra2, da, rd1, rd2, dd, exp_read(ra1), exp_read(ra2), exp_debug(da));
      end
      tick();
    end
    reset = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; da = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    test_reset();
    test_write_bypass();
    test_zero();
    test_dual_bypass_reset_wins();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
